sram_arb_wrap: RTL

SRAM_ARB_WRAP -- requirements
Module: sram_arb_wrap

---
 rtl/sram_pkg.sv | 26 ++
 rtl/sram_port_decode.sv | 47 ++++
 rtl/sram_arb_wrap.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared constants and types for the SRAM arbitration wrapper.
//   DEFAULT_*     : default window base, macro count and macro depth
//   WORD_IDX_W    : word-index width of one macro at the default depth
//   BANK_IDX_W    : bank-index width at the default macro count
//   sram_resp_t   : per-port response bundle (rvalid, err, rdata)
//   idx_width()   : index width for n items, never less than one bit
package sram_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR      = 32'h8000_0000;
    localparam int unsigned DEFAULT_NUM_BLOCKS     = 4;
    localparam int unsigned DEFAULT_LOG_BLOCK_SIZE = 9;
    localparam int unsigned DATA_W                 = 32;
    localparam int unsigned WORD_IDX_W             = DEFAULT_LOG_BLOCK_SIZE;
    localparam int unsigned BANK_IDX_W             = $clog2(DEFAULT_NUM_BLOCKS);

    typedef struct packed {
        logic              rvalid;
        logic              err;
        logic [DATA_W-1:0] rdata;
    } sram_resp_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sram_port_decode.sv
// Address decoder for one OBI port of the SRAM wrapper.
//   addr_i    : byte address of the request
//   we_i      : write enable of the request
//   legal_o   : request may touch a macro
//   bank_oh_o : one-hot macro select
//   word_o    : word index inside the selected macro
// SRAM_ERR_RESP_EN: when defined, addresses outside the window (and writes
// on a READ_ONLY port) are illegal; otherwise every access is legal and
// addresses alias modulo the window.
module sram_port_decode
    import sram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = DEFAULT_BASE_ADDR,
    parameter int unsigned NUM_BLOCKS     = DEFAULT_NUM_BLOCKS,
    parameter int unsigned LOG_BLOCK_SIZE = DEFAULT_LOG_BLOCK_SIZE,
    parameter bit          READ_ONLY      = 1'b0
) (
    input  logic [31:0]               addr_i,
    input  logic                      we_i,
    output logic                      legal_o,
    output logic [NUM_BLOCKS-1:0]     bank_oh_o,
    output logic [LOG_BLOCK_SIZE-1:0] word_o
);

    localparam int unsigned      BANK_W    = idx_width(NUM_BLOCKS);
    localparam logic [BANK_W-1:0] BANK_MASK = BANK_W'(NUM_BLOCKS - 1);

    logic [31:0]       offset;
    logic [BANK_W-1:0] bank_idx;

    // Offset from the base makes an unaligned base alias the same way as an
    // aligned one; addresses below the base wrap to huge offsets.
    assign offset    = addr_i - BASE_ADDR;
    assign word_o    = offset[LOG_BLOCK_SIZE+1:2];
    assign bank_idx  = offset[LOG_BLOCK_SIZE+2 +: BANK_W] & BANK_MASK;
    assign bank_oh_o = NUM_BLOCKS'(1) << bank_idx;

`ifdef SRAM_ERR_RESP_EN
    localparam logic [31:0] WINDOW_BYTES = 32'(NUM_BLOCKS) << (LOG_BLOCK_SIZE + 2);
    assign legal_o = (offset < WINDOW_BYTES) && !(READ_ONLY && we_i);
`else
    logic unused_bits;
    assign unused_bits = ^{we_i, offset[31:LOG_BLOCK_SIZE+2+BANK_W], offset[1:0]};
    assign legal_o     = 1'b1;
`endif

endmodule

// File: rtl/sram_arb_wrap.sv
// Two-port (data rw, instruction ro) OBI front end over a bank of 1rw1r
// SRAM macros. Data port uses macro port 0, instruction port uses port 1.
//   clk_i, rst_i                  : clock, synchronous active-high reset
//   d_req_i/d_gnt_o/d_we_i        : data request handshake and write enable
//   d_addr_i/d_be_i/d_wdata_i     : data address, byte enables, write data
//   d_rvalid_o/d_err_o/d_rdata_o  : data response (one cycle after grant)
//   i_req_i/i_gnt_o/i_we_i/i_addr_i : instruction request (read-only port)
//   i_rvalid_o/i_err_o/i_rdata_o  : instruction response
//   illegal_memory_o              : pulses with any error response
// SRAM_ERR_RESP_EN: enables the window / read-only error checks.
module sram_arb_wrap
    import sram_pkg::*;
#(
    parameter logic [31:0] SRAM_BASE_ADDR      = DEFAULT_BASE_ADDR,
    parameter int unsigned SRAM_NUM_BLOCKS     = DEFAULT_NUM_BLOCKS,
    parameter int unsigned SRAM_LOG_BLOCK_SIZE = DEFAULT_LOG_BLOCK_SIZE,
    parameter int unsigned STALL_MAX           = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        d_req_i,
    output logic        d_gnt_o,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [3:0]  d_be_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_rvalid_o,
    output logic        d_err_o,
    output logic [31:0] d_rdata_o,
    input  logic        i_req_i,
    output logic        i_gnt_o,
    input  logic        i_we_i,
    input  logic [31:0] i_addr_i,
    output logic        i_rvalid_o,
    output logic        i_err_o,
    output logic [31:0] i_rdata_o,
    output logic        illegal_memory_o
);

    localparam int unsigned NB    = SRAM_NUM_BLOCKS;
    localparam int unsigned LBS   = SRAM_LOG_BLOCK_SIZE;
    localparam int unsigned WORDS = 1 << LBS;

    logic           d_legal, i_legal;
    logic [NB-1:0]  d_bank_oh, i_bank_oh;
    logic [LBS-1:0] d_word, i_word;

    sram_port_decode #(
        .BASE_ADDR      (SRAM_BASE_ADDR),
        .NUM_BLOCKS     (NB),
        .LOG_BLOCK_SIZE (LBS),
        .READ_ONLY      (1'b0)
    ) u_d_decode (
        .addr_i    (d_addr_i),
        .we_i      (d_we_i),
        .legal_o   (d_legal),
        .bank_oh_o (d_bank_oh),
        .word_o    (d_word)
    );

    sram_port_decode #(
        .BASE_ADDR      (SRAM_BASE_ADDR),
        .NUM_BLOCKS     (NB),
        .LOG_BLOCK_SIZE (LBS),
        .READ_ONLY      (1'b1)
    ) u_i_decode (
        .addr_i    (i_addr_i),
        .we_i      (i_we_i),
        .legal_o   (i_legal),
        .bank_oh_o (i_bank_oh),
        .word_o    (i_word)
    );

    // Arbitration: a data write to the exact word being fetched wins, unless
    // the instruction port has already lost STALL_MAX cycles in a row.
    logic [3:0] stall_cnt_q;
    logic       collision, holdoff, d_gnt, i_gnt;

    always_comb begin
        holdoff   = i_req_i && (stall_cnt_q == 4'(STALL_MAX));
        collision = d_req_i && d_we_i && d_legal && i_req_i && i_legal &&
                    (d_bank_oh == i_bank_oh) && (d_word == i_word);
        d_gnt     = d_req_i && !holdoff;
        i_gnt     = i_req_i && (!collision || holdoff);
    end

    assign d_gnt_o = d_gnt;
    assign i_gnt_o = i_gnt;

    // A pending, ungranted instruction request can only mean a collision.
    always_ff @(posedge clk_i) begin
        if (rst_i || !i_req_i || i_gnt) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_q + 4'd1;
        end
    end

    logic [NB-1:0] d_cs, i_cs;
    assign d_cs = (!rst_i && d_gnt && d_legal) ? d_bank_oh : '0;
    assign i_cs = (!rst_i && i_gnt && i_legal) ? i_bank_oh : '0;

    logic [NB-1:0][31:0] d_dout, i_dout;

    for (genvar b = 0; b < NB; b++) begin : g_bank
        logic [31:0] mem [WORDS];
        logic [31:0] dout0_q, dout1_q;

        always_ff @(posedge clk_i) begin
            if (d_cs[b]) begin
                if (d_we_i) begin
                    for (int unsigned k = 0; k < 4; k++) begin
                        if (d_be_i[k]) begin
                            mem[d_word][8*k +: 8] <= d_wdata_i[8*k +: 8];
                        end
                    end
                end else begin
                    dout0_q <= mem[d_word];
                end
            end
            if (i_cs[b]) begin
                dout1_q <= mem[i_word];
            end
        end

        assign d_dout[b] = dout0_q;
        assign i_dout[b] = dout1_q;
    end

    // Captured bank selects are non-zero only for a granted legal read, so
    // rdata is zero for writes, errors and idle cycles.
    logic          d_rvalid_q, d_err_q, i_rvalid_q, i_err_q;
    logic [NB-1:0] d_rd_bank_q, i_rd_bank_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            d_rvalid_q  <= 1'b0;
            d_err_q     <= 1'b0;
            d_rd_bank_q <= '0;
            i_rvalid_q  <= 1'b0;
            i_err_q     <= 1'b0;
            i_rd_bank_q <= '0;
        end else begin
            d_rvalid_q  <= d_gnt;
            d_err_q     <= d_gnt && !d_legal;
            d_rd_bank_q <= d_we_i ? '0 : d_cs;
            i_rvalid_q  <= i_gnt;
            i_err_q     <= i_gnt && !i_legal;
            i_rd_bank_q <= i_cs;
        end
    end

    sram_resp_t d_resp, i_resp;

    always_comb begin
        d_resp        = '0;
        i_resp        = '0;
        d_resp.rvalid = d_rvalid_q;
        d_resp.err    = d_err_q;
        i_resp.rvalid = i_rvalid_q;
        i_resp.err    = i_err_q;
        for (int unsigned b = 0; b < NB; b++) begin
            if (d_rd_bank_q[b]) d_resp.rdata = d_resp.rdata | d_dout[b];
            if (i_rd_bank_q[b]) i_resp.rdata = i_resp.rdata | i_dout[b];
        end
    end

    assign d_rvalid_o       = d_resp.rvalid;
    assign d_err_o          = d_resp.err;
    assign d_rdata_o        = d_resp.rdata;
    assign i_rvalid_o       = i_resp.rvalid;
    assign i_err_o          = i_resp.err;
    assign i_rdata_o        = i_resp.rdata;
    assign illegal_memory_o = d_resp.err | i_resp.err;

endmodule
